// File: rtl/pic_pkg.sv
// Shared types and constants for the PIC acknowledge path.
// The acknowledge sequencer and the read/write strobe logic both use these.
package pic_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACK1  = 3'd1,
        WAIT2 = 3'd2,
        ACK2  = 3'd3,
        WAIT3 = 3'd4,
        ACK3  = 3'd5
    } ack_state_e;

    localparam logic MODE_8086 = 1'b1;
    localparam logic MODE_8080 = 1'b0;

    localparam logic [1:0] PHASE_IDLE = 2'd0;
    localparam logic [1:0] PHASE_1    = 2'd1;
    localparam logic [1:0] PHASE_2    = 2'd2;
    localparam logic [1:0] PHASE_3    = 2'd3;

    function automatic logic [1:0] phase_of(input ack_state_e s);
        case (s)
            ACK1, WAIT2: return PHASE_1;
            ACK2, WAIT3: return PHASE_2;
            ACK3:        return PHASE_3;
            default:     return PHASE_IDLE;
        endcase
    endfunction

    // 8086 only drives the vector byte during pulse 2; 8080 drives all three.
    function automatic logic drive_of(input ack_state_e s, input logic mode);
        case (s)
            ACK1, ACK3: return (mode == MODE_8080);
            ACK2:       return 1'b1;
            default:    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/pic_sync_edge.sv
// Multi-flop synchroniser for an active-low asynchronous strobe with
// registered edge detection; reused for INTA_n, WR_n and RD_n.
module pic_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic strobe_n_i,
    output logic fall_o,
    output logic rise_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] seen_q;
    logic              last_q;
    logic              seen_last_q;

    // seen_q tracks, in step with the data path, whether a genuine high has
    // been sampled since reset. Without it a strobe still low at reset release
    // would look like a fresh falling edge against the preset-high flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= '1;
            seen_q      <= '0;
            last_q      <= 1'b1;
            seen_last_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[STAGES-2:0], strobe_n_i};
            seen_q      <= {seen_q[STAGES-2:0], seen_q[0] | strobe_n_i};
            last_q      <= sync_q[STAGES-1];
            seen_last_q <= seen_q[STAGES-1];
        end
    end

    assign fall_o = last_q & ~sync_q[STAGES-1] & seen_last_q;
    assign rise_o = ~last_q & sync_q[STAGES-1];

endmodule

// File: rtl/inta_sequencer.sv
// Interrupt-acknowledge sequencer: counts INTA_n pulses and issues the
// phase strobes and data-bus drive enable used by the priority resolver.
//
// state | meaning
// IDLE  | no acknowledge in progress
// ACK1  | INTA_n low, pulse 1
// WAIT2 | between pulse 1 and 2, timeout running
// ACK2  | INTA_n low, pulse 2
// WAIT3 | between pulse 2 and 3 (8080 only), timeout running
// ACK3  | INTA_n low, pulse 3 (8080 only)
module inta_sequencer
    import pic_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inta_n,
    input  logic       endOfinit,
    input  logic       int_pending,
    input  logic       upm,
    output logic       imp1,
    output logic       endOfimp1,
    output logic       imp2,
    output logic       endOfimp2,
    output logic       imp3,
    output logic       endOfimp3,
    output logic       data_drive,
    output logic [1:0] ack_phase,
    output logic       spurious,
    output logic       timeout_abort,
    output logic       busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic fall;
    logic rise;

    ack_state_e       state_q, state_d;
    logic             mode_q, mode_d;
    logic             spur_q, spur_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       strb_q, strb_d;   // imp1, eoi1, imp2, eoi2, imp3, eoi3
    logic             abort_q, abort_d;
    logic             drive_q, drive_d;
    logic [1:0]       phase_q, phase_d;

    pic_sync_edge #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .strobe_n_i(inta_n),
        .fall_o    (fall),
        .rise_o    (rise)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mode_q  <= MODE_8080;
            spur_q  <= 1'b0;
            cnt_q   <= '0;
            strb_q  <= '0;
            abort_q <= 1'b0;
            drive_q <= 1'b0;
            phase_q <= PHASE_IDLE;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            spur_q  <= spur_d;
            cnt_q   <= cnt_d;
            strb_q  <= strb_d;
            abort_q <= abort_d;
            drive_q <= drive_d;
            phase_q <= phase_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        spur_d  = spur_q;
        cnt_d   = cnt_q;
        strb_d  = '0;
        abort_d = 1'b0;

        // Losing the initialisation mid-sequence abandons it without strobes.
        if ((state_q != IDLE) && !endOfinit) begin
            state_d = IDLE;
            abort_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fall && endOfinit) begin
                        state_d   = ACK1;
                        strb_d[0] = 1'b1;
                        mode_d    = upm;
                        spur_d    = ~int_pending;
                    end
                end
                ACK1: begin
                    if (rise) begin
                        state_d   = WAIT2;
                        strb_d[1] = 1'b1;
                        cnt_d     = '0;
                    end
                end
                WAIT2: begin
                    if (fall) begin
                        state_d   = ACK2;
                        strb_d[2] = 1'b1;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = IDLE;
                        abort_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ACK2: begin
                    if (rise) begin
                        strb_d[3] = 1'b1;
                        cnt_d     = '0;
                        state_d   = (mode_q == MODE_8080) ? WAIT3 : IDLE;
                    end
                end
                WAIT3: begin
                    if (fall) begin
                        state_d   = ACK3;
                        strb_d[4] = 1'b1;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = IDLE;
                        abort_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ACK3: begin
                    if (rise) begin
                        state_d   = IDLE;
                        strb_d[5] = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (state_d == IDLE) begin
            spur_d = 1'b0;
            cnt_d  = '0;
        end

        drive_d = drive_of(state_d, mode_d);
        phase_d = phase_of(state_d);
    end

    assign imp1          = strb_q[0];
    assign endOfimp1     = strb_q[1];
    assign imp2          = strb_q[2];
    assign endOfimp2     = strb_q[3];
    assign imp3          = strb_q[4];
    assign endOfimp3     = strb_q[5];
    assign data_drive    = drive_q;
    assign ack_phase     = phase_q;
    assign spurious      = spur_q;
    assign timeout_abort = abort_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_inta_sequencer.sv
// Self-checking bench for inta_sequencer: a scoreboard of expected strobe
// codes and cycles, plus per-scenario checks of the level outputs.
module tb_inta_sequencer;

    logic       clk;
    logic       rst_n;
    logic       inta_n;
    logic       endOfinit;
    logic       int_pending;
    logic       upm;
    logic       imp1, endOfimp1, imp2, endOfimp2, imp3, endOfimp3;
    logic       data_drive;
    logic [1:0] ack_phase;
    logic       spurious;
    logic       timeout_abort;
    logic       busy;

    inta_sequencer #(
        .SYNC_STAGES   (2),
        .TIMEOUT_CYCLES(64),
        .CNT_W         (7)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .inta_n       (inta_n),
        .endOfinit    (endOfinit),
        .int_pending  (int_pending),
        .upm          (upm),
        .imp1         (imp1),
        .endOfimp1    (endOfimp1),
        .imp2         (imp2),
        .endOfimp2    (endOfimp2),
        .imp3         (imp3),
        .endOfimp3    (endOfimp3),
        .data_drive   (data_drive),
        .ack_phase    (ack_phase),
        .spurious     (spurious),
        .timeout_abort(timeout_abort),
        .busy         (busy)
    );

    typedef struct {
        int code;
        int cyc;
    } ev_t;

    // codes: 1 imp1, 2 endOfimp1, 3 imp2, 4 endOfimp2, 5 imp3, 6 endOfimp3, 7 timeout_abort
    ev_t  exp_q[$];
    ev_t  mon_e;
    logic [6:0] mon_v;
    int   cyc;
    int   checks;
    int   passed;

    logic       smp_dd[3];
    logic [1:0] smp_ph[3];
    logic       smp_sp[3];

    logic [11:0] all_out;
    assign all_out = {imp1, endOfimp1, imp2, endOfimp2, imp3, endOfimp3,
                      data_drive, ack_phase, spurious, timeout_abort, busy};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Every strobe the DUT raises must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            mon_v = {timeout_abort, endOfimp3, imp3, endOfimp2, imp2, endOfimp1, imp1};
            for (int k = 0; k < 7; k++) begin
                if (mon_v[k] !== 1'b0) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL unexpected_strobe got code=%0d at cycle %0d, want none", k + 1, cyc);
                    end else begin
                        mon_e = exp_q.pop_front();
                        if (mon_e.code != k + 1 || mon_e.cyc != cyc)
                            $display("FAIL strobe_order got code=%0d at cycle %0d, want code=%0d at cycle %0d",
                                     k + 1, cyc, mon_e.code, mon_e.cyc);
                        else
                            passed++;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish, got cycle %0d want completion", cyc);
        $fatal(1, "watchdog");
    end

    task automatic push_ev(input int code, input int at);
        exp_q.push_back('{code: code, cyc: at});
    endtask

    task automatic inta_at(input int dly, input logic v, output int c);
        repeat (dly) @(posedge clk);
        #1;
        inta_n = v;
        c = cyc;
    endtask

    // n pulses of 4 clocks low, 3 clocks high; samples level outputs in each pulse.
    task automatic pulse_seq(input int n, input int first_idx, input int first_wait,
                             input bit expect_ev, output int last_rise);
        int c;
        c = 0;
        for (int k = 0; k < n; k++) begin
            inta_at((k == 0) ? first_wait : 3, 1'b0, c);
            if (expect_ev) push_ev(1 + 2 * (first_idx + k), c + 3);
            inta_at(4, 1'b1, c);
            @(negedge clk);
            smp_dd[first_idx + k] = data_drive;
            smp_ph[first_idx + k] = ack_phase;
            smp_sp[first_idx + k] = spurious;
            if (expect_ev) push_ev(2 + 2 * (first_idx + k), c + 3);
        end
        last_rise = c;
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0)
            $display("FAIL %s_pending got %0d outstanding strobes want 0", name, exp_q.size());
        else
            passed++;
        exp_q.delete();
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (all_out !== 12'd0)
            $display("FAIL %s_idle got outputs=%b want all zero", name, all_out);
        else
            passed++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset_hold");
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_idle("reset_release");
    endtask

    task automatic test_8086();
        int r;
        endOfinit = 1'b1; int_pending = 1'b1; upm = 1'b1;
        pulse_seq(2, 0, 2, 1'b1, r);
        checks++;
        if (smp_dd[0] !== 1'b0 || smp_dd[1] !== 1'b1)
            $display("FAIL 8086_data_drive got %b%b want 01", smp_dd[0], smp_dd[1]);
        else passed++;
        checks++;
        if (smp_ph[0] !== 2'd1 || smp_ph[1] !== 2'd2)
            $display("FAIL 8086_ack_phase got %0d,%0d want 1,2", smp_ph[0], smp_ph[1]);
        else passed++;
        repeat (5) @(negedge clk);
        check_idle("8086_end");
        check_drained("8086");
    endtask

    task automatic test_8080();
        int r;
        upm = 1'b0;
        pulse_seq(3, 0, 2, 1'b1, r);
        checks++;
        if (smp_dd[0] !== 1'b1 || smp_dd[1] !== 1'b1 || smp_dd[2] !== 1'b1)
            $display("FAIL 8080_data_drive got %b%b%b want 111", smp_dd[0], smp_dd[1], smp_dd[2]);
        else passed++;
        checks++;
        if (smp_ph[0] !== 2'd1 || smp_ph[1] !== 2'd2 || smp_ph[2] !== 2'd3)
            $display("FAIL 8080_ack_phase got %0d,%0d,%0d want 1,2,3", smp_ph[0], smp_ph[1], smp_ph[2]);
        else passed++;
        repeat (5) @(negedge clk);
        check_idle("8080_end");
        check_drained("8080");
        upm = 1'b1;
    endtask

    task automatic test_timeout();
        int r;
        pulse_seq(1, 0, 2, 1'b1, r);
        // WAIT2 is entered on edge r+3; abort lands 64 edges later.
        push_ev(7, r + 3 + 64);
        while (cyc < r + 3 + 63) @(negedge clk);
        checks++;
        if (busy !== 1'b1)
            $display("FAIL timeout_early got busy=%b want 1 at cycle %0d", busy, cyc);
        else passed++;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || timeout_abort !== 1'b1)
            $display("FAIL timeout_fire got busy=%b abort=%b want busy=0 abort=1", busy, timeout_abort);
        else passed++;
        repeat (3) @(negedge clk);
        check_idle("timeout_end");
        check_drained("timeout");
    endtask

    task automatic test_spurious();
        int r;
        int_pending = 1'b0;
        pulse_seq(2, 0, 2, 1'b1, r);
        checks++;
        if (smp_sp[0] !== 1'b1 || smp_sp[1] !== 1'b1)
            $display("FAIL spurious_held got %b%b want 11", smp_sp[0], smp_sp[1]);
        else passed++;
        repeat (2) @(negedge clk);
        checks++;
        if (spurious !== 1'b1)
            $display("FAIL spurious_before_end got %b want 1", spurious);
        else passed++;
        @(negedge clk);
        checks++;
        if (spurious !== 1'b0 || endOfimp2 !== 1'b1)
            $display("FAIL spurious_clear got spurious=%b endOfimp2=%b want 0,1", spurious, endOfimp2);
        else passed++;
        int_pending = 1'b1;
        repeat (3) @(negedge clk);
        check_drained("spurious");
    endtask

    task automatic test_disable();
        int r;
        int c;
        endOfinit = 1'b0;
        pulse_seq(2, 0, 2, 1'b0, r);
        repeat (6) @(negedge clk);
        check_idle("disable_idle");
        check_drained("disable_idle");
        endOfinit = 1'b1;
        inta_at(2, 1'b0, c);
        push_ev(1, c + 3);
        repeat (5) @(posedge clk);
        #1 endOfinit = 1'b0;
        push_ev(7, cyc + 1);
        inta_at(2, 1'b1, c);
        repeat (6) @(negedge clk);
        check_idle("disable_mid");
        check_drained("disable_mid");
        endOfinit = 1'b1;
    endtask

    task automatic test_reset_mid();
        int c;
        int r;
        inta_at(2, 1'b0, c);
        push_ev(1, c + 3);
        inta_at(4, 1'b1, c);
        push_ev(2, c + 3);
        inta_at(3, 1'b0, c);
        push_ev(3, c + 3);
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (ack_phase !== 2'd2 || data_drive !== 1'b1)
            $display("FAIL reset_mid_pre got phase=%0d dd=%b want 2,1", ack_phase, data_drive);
        else passed++;
        rst_n = 1'b0;
        #1;
        check_idle("reset_mid_async");
        check_drained("reset_mid_pre");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check_idle("reset_mid_low");
        inta_at(1, 1'b1, c);
        pulse_seq(2, 0, 4, 1'b1, r);
        repeat (5) @(negedge clk);
        check_idle("reset_mid_end");
        check_drained("reset_mid");
    endtask

    task automatic test_mode_change();
        int r;
        upm = 1'b1;
        pulse_seq(1, 0, 2, 1'b1, r);
        repeat (4) @(posedge clk);
        #1 upm = 1'b0;
        pulse_seq(1, 1, 1, 1'b1, r);
        repeat (8) @(negedge clk);
        check_idle("mode_change_end");
        check_drained("mode_change");
        upm = 1'b1;
    endtask

    task automatic test_back_to_back();
        int r;
        pulse_seq(2, 0, 2, 1'b1, r);
        // Next fall is seen in the very cycle the FSM is back in IDLE.
        pulse_seq(2, 0, 1, 1'b1, r);
        repeat (5) @(negedge clk);
        check_idle("back_to_back_end");
        check_drained("back_to_back");
    endtask

    initial begin
        checks      = 0;
        passed      = 0;
        rst_n       = 1'b0;
        inta_n      = 1'b1;
        endOfinit   = 1'b0;
        int_pending = 1'b1;
        upm         = 1'b1;
        test_reset();
        test_8086();
        test_8080();
        test_timeout();
        test_spurious();
        test_disable();
        test_reset_mid();
        test_mode_change();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
